// File: rtl/life_grid_reader.sv
// Captures an N x N cell grid on request and streams it row by row over a valid/ready handshake.
// Optional STILL_LIFE_DETECT_EN adds a 'stable' output flagging a capture identical to the previous one.
module life_grid_reader #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [N*N-1:0]  cells,
  input  logic            snap_req,
  output logic            busy,
  output logic            row_valid,
  input  logic            row_ready,
  output logic [N-1:0]    row_data,
  output logic [IW-1:0]   row_idx,
  output logic            row_last,
`ifdef STILL_LIFE_DETECT_EN
  output logic            stable,
`endif
  output logic            overrun
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic [N*N-1:0]   snap_q, snap_d;
  logic [IW-1:0]    row_q, row_d;
  logic             overrun_q, overrun_d;
  logic             capture;
  logic             xfer;
  logic             last_row;

  assign last_row = (row_q == IW'(N-1));

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    row_d     = row_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    xfer      = (state_q == SEND) && row_ready;

    case (state_q)
      IDLE: begin
        if (snap_req) capture = 1'b1;
      end
      SEND: begin
        if (xfer) begin
          if (last_row) begin
            if (snap_req) begin
              capture = 1'b1;
            end else begin
              state_d = IDLE;
              row_d   = '0;
            end
          end else begin
            row_d = row_q + IW'(1);
          end
        end
        // A request is only honoured when it lands on the final-row handshake.
        if (snap_req && !(xfer && last_row)) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      snap_d  = cells;
      row_d   = '0;
      state_d = SEND;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      row_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      row_q     <= row_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef STILL_LIFE_DETECT_EN
  logic stable_q, stable_d;
  logic hist_valid_q, hist_valid_d;

  always_comb begin
    stable_d     = stable_q;
    hist_valid_d = hist_valid_q;
    if (capture) begin
      stable_d     = hist_valid_q && (cells == snap_q);
      hist_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stable_q     <= 1'b0;
      hist_valid_q <= 1'b0;
    end else begin
      stable_q     <= stable_d;
      hist_valid_q <= hist_valid_d;
    end
  end

  assign stable = stable_q;
`endif

  always_comb begin
    busy      = (state_q == SEND);
    row_valid = (state_q == SEND);
    row_idx   = '0;
    row_last  = 1'b0;
    row_data  = '0;
    if (state_q == SEND) begin
      row_idx  = row_q;
      row_last = last_row;
      for (int unsigned r = 0; r < N; r++) begin
        if (row_q == IW'(r)) row_data = snap_q[r*N +: N];
      end
    end
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_life_grid_reader.sv
// Directed bench for life_grid_reader (N=4): streaming, backpressure, back-to-back frames, overrun, reset abort.
module tb_life_grid_reader;

  logic        clk;
  logic        nrst;
  logic [15:0] cells;
  logic        snap_req;
  logic        busy;
  logic        row_valid;
  logic        row_ready;
  logic [3:0]  row_data;
  logic [1:0]  row_idx;
  logic        row_last;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  life_grid_reader #(.N(4)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cells     (cells),
    .snap_req  (snap_req),
    .busy      (busy),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_row(input string tag, input logic [3:0] data, input logic [1:0] idx,
                            input logic last, input logic ovr);
    check({tag, "_busy"},  32'(busy), 32'd1);
    check({tag, "_valid"}, 32'(row_valid), 32'd1);
    check({tag, "_data"},  32'(row_data), 32'(data));
    check({tag, "_idx"},   32'(row_idx), 32'(idx));
    check({tag, "_last"},  32'(row_last), 32'(last));
    check({tag, "_ovr"},   32'(overrun), 32'(ovr));
  endtask

  task automatic expect_idle(input string tag, input logic ovr);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(row_valid), 32'd0);
    check({tag, "_data"},  32'(row_data), 32'd0);
    check({tag, "_idx"},   32'(row_idx), 32'd0);
    check({tag, "_last"},  32'(row_last), 32'd0);
    check({tag, "_ovr"},   32'(overrun), 32'(ovr));
  endtask

  initial begin
    nrst      = 1'b0;
    cells     = 16'h0;
    snap_req  = 1'b0;
    row_ready = 1'b1;
    #2;
    expect_idle("reset", 1'b0);
    step();
    step();
    expect_idle("reset_hold", 1'b0);

    // Basic frame; request issued on the first edge after reset release.
    nrst     = 1'b1;
    cells    = 16'hA5C3;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    expect_row("f1_r0", 4'h3, 2'd0, 1'b0, 1'b0);
    step(); expect_row("f1_r1", 4'hC, 2'd1, 1'b0, 1'b0);
    step(); expect_row("f1_r2", 4'h5, 2'd2, 1'b0, 1'b0);
    step(); expect_row("f1_r3", 4'hA, 2'd3, 1'b1, 1'b0);
    step(); expect_idle("f1_end", 1'b0);
    step(); expect_idle("f1_end2", 1'b0);

    // Backpressure on row 1 with cells changing mid-frame.
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    expect_row("f2_r0", 4'h3, 2'd0, 1'b0, 1'b0);
    step();
    row_ready = 1'b0;
    cells     = 16'h0000;
    expect_row("f2_r1", 4'hC, 2'd1, 1'b0, 1'b0);
    step(); expect_row("f2_hold1", 4'hC, 2'd1, 1'b0, 1'b0);
    step(); expect_row("f2_hold2", 4'hC, 2'd1, 1'b0, 1'b0);
    step(); expect_row("f2_hold3", 4'hC, 2'd1, 1'b0, 1'b0);
    row_ready = 1'b1;
    step(); expect_row("f2_r2", 4'h5, 2'd2, 1'b0, 1'b0);
    step(); expect_row("f2_r3", 4'hA, 2'd3, 1'b1, 1'b0);
    step(); expect_idle("f2_end", 1'b0);

    // Back-to-back frames via request on the final handshake, then an overrun.
    cells    = 16'hA5C3;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    expect_row("f3_r0", 4'h3, 2'd0, 1'b0, 1'b0);
    step(); expect_row("f3_r1", 4'hC, 2'd1, 1'b0, 1'b0);
    step(); expect_row("f3_r2", 4'h5, 2'd2, 1'b0, 1'b0);
    step();
    expect_row("f3_r3", 4'hA, 2'd3, 1'b1, 1'b0);
    cells    = 16'h1234;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    expect_row("f4_r0", 4'h4, 2'd0, 1'b0, 1'b0);
    step();
    expect_row("f4_r1", 4'h3, 2'd1, 1'b0, 1'b0);
    cells    = 16'hFFFF;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    expect_row("f4_r2", 4'h2, 2'd2, 1'b0, 1'b1);
    step(); expect_row("f4_r3", 4'h1, 2'd3, 1'b1, 1'b1);
    step(); expect_idle("f4_end", 1'b1);
    step(); expect_idle("f4_sticky", 1'b1);

    // Reset asserted while row 2 is presented.
    cells    = 16'hA5C3;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    expect_row("f5_r0", 4'h3, 2'd0, 1'b0, 1'b1);
    step(); expect_row("f5_r1", 4'hC, 2'd1, 1'b0, 1'b1);
    step(); expect_row("f5_r2", 4'h5, 2'd2, 1'b0, 1'b1);
    #2;
    nrst = 1'b0;
    #1;
    expect_idle("rst_mid", 1'b0);
    step();
    nrst = 1'b1;
    step(); expect_idle("post_rst1", 1'b0);
    step(); expect_idle("post_rst2", 1'b0);
    step(); expect_idle("post_rst3", 1'b0);

    // New request after reset restarts cleanly.
    cells    = 16'h8421;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    expect_row("f6_r0", 4'h1, 2'd0, 1'b0, 1'b0);
    step(); expect_row("f6_r1", 4'h2, 2'd1, 1'b0, 1'b0);
    step(); expect_row("f6_r2", 4'h4, 2'd2, 1'b0, 1'b0);
    step(); expect_row("f6_r3", 4'h8, 2'd3, 1'b1, 1'b0);
    step(); expect_idle("f6_end", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_grid_reader.md
LIFE_GRID_READER -- requirements
Module: life_grid_reader

Interface
REQ-001 Parameter N, default 4, grid edge length (N >= 2); grid is N*N cells.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 nrst  input  1  asynchronous, active-low reset.
REQ-004 cells  input  N*N  live grid state; cell (i,j) at bit i*N+j.
REQ-005 snap_req  input  1  request to capture one grid snapshot and stream it.
REQ-006 busy  output  1  high while a snapshot is being streamed.
REQ-007 row_valid  output  1  row word available.
REQ-008 row_ready  input  1  downstream accepts row word.
REQ-009 row_data  output  N  row word; bit j = cell (row_idx, j).
REQ-010 row_idx  output  max(1,$clog2(N))  index of row on row_data.
REQ-011 row_last  output  1  high with row N-1.
REQ-012 overrun  output  1  sticky flag: snap_req arrived while busy.
REQ-013 stable  output  1  present only with STILL_LIFE_DETECT_EN; snapshot equals previous snapshot.

Function
REQ-014 The FSM SHALL have two states: IDLE and SEND.
REQ-015 In IDLE, snap_req=1 at edge k SHALL copy cells into an internal snapshot register, clear the row counter, and enter SEND.
REQ-016 row_valid and busy SHALL be 1 from cycle k+1 (one-cycle capture latency), with row 0 presented.
REQ-017 row_data SHALL be snapshot[row_idx*N +: N]; later changes on cells SHALL NOT affect a frame in progress.
REQ-018 A transfer SHALL occur on an edge where row_valid=1 and row_ready=1; row_idx then increments.
REQ-019 While row_valid=1 and row_ready=0, row_data, row_idx and row_last SHALL hold stable.
REQ-020 row_valid SHALL NOT deassert in SEND until the row N-1 transfer completes.
REQ-021 On the transfer of row N-1 with snap_req=0, the FSM SHALL return to IDLE; busy and row_valid SHALL be 0 the next cycle.
REQ-022 On the transfer of row N-1 with snap_req=1, the block SHALL capture a new snapshot and stay in SEND with row 0 next cycle (no idle gap); overrun SHALL NOT be set.
REQ-023 snap_req=1 in SEND, other than the case in REQ-022, SHALL be ignored and SHALL set overrun to 1.
REQ-024 overrun SHALL remain 1 until reset.
REQ-025 In IDLE, row_data and row_idx SHALL be 0 and row_last SHALL be 0.

Reset
REQ-026 nrst=0 SHALL immediately force IDLE, busy=0, row_valid=0, row_last=0, row_idx=0, row_data=0, overrun=0, and clear the snapshot (and stable and its history-valid flag, when present).
REQ-027 Reset asserted mid-frame SHALL abort the frame; no further rows SHALL be emitted after release without a new snap_req.
REQ-028 After nrst deassertion, the first snap_req SHALL be honoured on the first rising edge.

Configuration
REQ-029 Macro STILL_LIFE_DETECT_EN: when defined, each capture SHALL compare cells with the previous snapshot; stable SHALL update at k+1 to 1 if they are equal and a prior capture exists since reset, else 0.
REQ-030 stable SHALL hold its value between captures.
REQ-031 Without STILL_LIFE_DETECT_EN, the stable port and the comparison logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-032 N=4, cells=16'hA5C3, snap_req pulse, row_ready=1 -> rows 3,C,5,A on idx 0..3 over 4 consecutive cycles; row_last only with A; busy low after.
REQ-033 Same frame, row_ready low for 3 cycles at row 1 -> row_data=C and row_idx=1 held throughout; cells changing to 0 mid-frame has no effect on rows 2-3.
REQ-034 snap_req during row 1 -> request dropped, overrun=1 stays 1; snap_req coincident with row 3 handshake -> row 0 of the new snapshot next cycle, busy continuous.
REQ-035 nrst low during row 2 -> all outputs 0 at once; after release, no rows until a new snap_req.
REQ-036 STILL_LIFE_DETECT_EN: capture 16'h0660 twice -> stable 0 after the first, 1 after the second; capture 16'h0670 -> stable 0.
